// File: rtl/periodic_flag_gen_if.sv
// Interface bundling the control, config and status signals of periodic_flag_gen.
// The oneshot/start/done signals exist only when PFG_ONESHOT_EN is defined.
interface periodic_flag_gen_if #(
    parameter int unsigned CNT_W = 23
);
    logic             en;
    logic             cfg_ld;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             flag;
    logic             tick;
    logic             cfg_pend;
`ifdef PFG_ONESHOT_EN
    logic             oneshot;
    logic             start;
    logic             done;

    modport master (
        output en, cfg_ld, cfg_period, cfg_high, oneshot, start,
        input  flag, tick, cfg_pend, done
    );
    modport slave (
        input  en, cfg_ld, cfg_period, cfg_high, oneshot, start,
        output flag, tick, cfg_pend, done
    );
`else
    modport master (
        output en, cfg_ld, cfg_period, cfg_high,
        input  flag, tick, cfg_pend
    );
    modport slave (
        input  en, cfg_ld, cfg_period, cfg_high,
        output flag, tick, cfg_pend
    );
`endif
endinterface

// File: rtl/periodic_flag_gen.sv
// Periodic flag/tick generator: programmable-duty square wave (flag) plus a
// one-cycle pulse on each period wrap (tick). Period and high time reload at
// runtime through shadow registers that take effect at the next wrap.
// Optional one-shot mode is compiled in with macro PFG_ONESHOT_EN.
module periodic_flag_gen #(
    parameter int unsigned CNT_W       = 23,
    parameter int unsigned PERIOD      = 5000000,
    parameter int unsigned HIGH_CYCLES = 2500000
) (
    input logic                clk1M,
    input logic                rst,
    periodic_flag_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] PeriodInit = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] HighInit   = CNT_W'(HIGH_CYCLES);
    localparam logic [CNT_W-1:0] One        = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic             pend_q, pend_d;
    logic             flag_q, flag_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] eff_period;
    logic             os_mode;
    logic             os_start;

`ifdef PFG_ONESHOT_EN
    assign os_mode  = bus.oneshot;
    assign os_start = bus.start;
    assign bus.done = done_q;
`else
    // Continuous-only build: done never sets, so the one-shot path folds away.
    assign os_mode  = 1'b0;
    assign os_start = 1'b0;
`endif

    // Next-state: counter, wrap handling, shadow capture/apply, one-shot stop.
    always_comb begin
        cnt_d       = cnt_q;
        period_d    = period_q;
        high_d      = high_q;
        sh_period_d = sh_period_q;
        sh_high_d   = sh_high_q;
        pend_d      = pend_q;
        flag_d      = flag_q;
        tick_d      = 1'b0;
        done_d      = done_q;
        // A programmed period of 0 behaves like 1.
        eff_period  = (period_q == '0) ? One : period_q;

        if (bus.en) begin
            if (done_q) begin
                if (os_start) begin
                    done_d = 1'b0;
                    cnt_d  = '0;
                    flag_d = (high_q != '0);
                end
            end else if (cnt_q == eff_period - One) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                // Old shadow applies here; a same-cycle cfg_ld is handled below.
                if (pend_q) begin
                    period_d = sh_period_q;
                    high_d   = sh_high_q;
                    pend_d   = 1'b0;
                end
                if (os_mode) begin
                    done_d = 1'b1;
                    flag_d = 1'b0;
                end else begin
                    flag_d = (high_d != '0);
                end
            end else begin
                cnt_d  = cnt_q + One;
                flag_d = (cnt_d < high_q);
            end
        end

        // Capture wins over the clear above so a load at the wrap stays pending.
        if (bus.cfg_ld) begin
            sh_period_d = bus.cfg_period;
            sh_high_d   = bus.cfg_high;
            pend_d      = 1'b1;
        end
    end

    // State registers with synchronous reset to the parameter defaults.
    always_ff @(posedge clk1M) begin
        if (rst) begin
            cnt_q       <= '0;
            period_q    <= PeriodInit;
            high_q      <= HighInit;
            sh_period_q <= '0;
            sh_high_q   <= '0;
            pend_q      <= 1'b0;
            flag_q      <= (HighInit != '0);
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            sh_period_q <= sh_period_d;
            sh_high_q   <= sh_high_d;
            pend_q      <= pend_d;
            flag_q      <= flag_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
        end
    end

    assign bus.flag     = flag_q;
    assign bus.tick     = tick_q;
    assign bus.cfg_pend = pend_q;
endmodule

// File: tb/tb_periodic_flag_gen.sv
// Randomized + directed bench for periodic_flag_gen against a behavioural model.
// Define PFG_ONESHOT_EN to also exercise the one-shot feature.
module tb_periodic_flag_gen;
    localparam int unsigned CntW   = 8;
    localparam int          Period = 10;
    localparam int          High   = 4;
`ifdef PFG_ONESHOT_EN
    localparam bit Oneshot = 1'b1;
`else
    localparam bit Oneshot = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    periodic_flag_gen_if #(.CNT_W(CntW)) bus ();

    periodic_flag_gen #(
        .CNT_W      (CntW),
        .PERIOD     (Period),
        .HIGH_CYCLES(High)
    ) dut (
        .clk1M(clk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_cnt, m_per, m_hi, m_sp, m_sh;
    bit m_pend, m_tick, m_done;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit ld, input int p, input int h,
                              input bit st, input bit os);
        int eff;
        if (r) begin
            m_cnt = 0; m_per = Period; m_hi = High;
            m_pend = 0; m_tick = 0; m_done = 0;
        end else begin
            m_tick = 0;
            if (e) begin
                if (m_done) begin
                    if (st) begin
                        m_done = 0;
                        m_cnt  = 0;
                    end
                end else begin
                    eff   = (m_per == 0) ? 1 : m_per;
                    m_cnt = (m_cnt + 1) % eff;
                    if (m_cnt == 0) begin
                        m_tick = 1;
                        if (m_pend) begin
                            m_per = m_sp; m_hi = m_sh; m_pend = 0;
                        end
                        if (Oneshot && os) m_done = 1;
                    end
                end
            end
            if (ld) begin
                m_sp = p; m_sh = h; m_pend = 1;
            end
        end
    endtask

    task automatic compare_all();
        int exp_flag;
        exp_flag = m_done ? 0 : int'(m_cnt < m_hi);
        check_eq("flag", int'(bus.flag), exp_flag);
        check_eq("tick", int'(bus.tick), int'(m_tick));
        check_eq("cfg_pend", int'(bus.cfg_pend), int'(m_pend));
`ifdef PFG_ONESHOT_EN
        check_eq("done", int'(bus.done), int'(m_done));
`endif
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge,
    // compare 1 time unit later.
    task automatic step(input bit r, input bit e, input bit ld, input int p, input int h,
                        input bit st, input bit os);
        @(negedge clk);
        rst            = r;
        bus.en         = e;
        bus.cfg_ld     = ld;
        bus.cfg_period = CntW'(p);
        bus.cfg_high   = CntW'(h);
`ifdef PFG_ONESHOT_EN
        bus.start      = st;
        bus.oneshot    = os;
`endif
        @(posedge clk);
        model_step(r, e, ld, p, h, st, os);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance (bounded) until the model counter equals target.
    task automatic run_to_cnt(input int target);
        for (int i = 0; i < 64 && m_cnt != target; i++) step(0, 1, 0, 0, 0, 0, 0);
        check_eq("reach_cnt", m_cnt, target);
    endtask

    initial begin
        int first_tick;
        int ticks;
        rst = 1'b1;
        bus.en = 1'b0; bus.cfg_ld = 1'b0; bus.cfg_period = '0; bus.cfg_high = '0;
`ifdef PFG_ONESHOT_EN
        bus.start = 1'b0; bus.oneshot = 1'b0;
`endif
        m_sp = 0; m_sh = 0;

        // Reset state
        do_reset();
        check_eq("rst_flag", int'(bus.flag), 1);
        check_eq("rst_tick", int'(bus.tick), 0);
        check_eq("rst_pend", int'(bus.cfg_pend), 0);

        // Default 10/4 waveform; first tick 10 cycles after release
        first_tick = -1;
        for (int i = 1; i <= 25; i++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            if (bus.tick && first_tick < 0) first_tick = i;
        end
        check_eq("first_tick_cycle", first_tick, 10);

        // Reload 6/3 at cnt==2
        run_to_cnt(2);
        step(0, 1, 1, 6, 3, 0, 0);
        check_eq("pend_after_ld", int'(bus.cfg_pend), 1);
        run(20);

        // Load at the wrap cycle, then overwrite before the next wrap
        run_to_cnt(5);
        step(0, 1, 1, 8, 2, 0, 0);
        step(0, 1, 1, 12, 5, 0, 0);
        check_eq("pend_last_write", int'(bus.cfg_pend), 1);
        run(30);

        // Boundaries: high=0, high>period, period=0, period=1
        step(0, 1, 1, 10, 0, 0, 0);
        run(25);
        check_eq("high0_flag", int'(bus.flag), 0);
        step(0, 1, 1, 10, 15, 0, 0);
        run(25);
        check_eq("high15_flag", int'(bus.flag), 1);
        step(0, 1, 1, 0, 1, 0, 0);
        run(15);
        check_eq("p0_tick", int'(bus.tick), 1);
        step(0, 1, 1, 1, 0, 0, 0);
        run(15);
        check_eq("p1_tick", int'(bus.tick), 1);

        // en low for 7 cycles mid-period, then resume
        do_reset();
        run_to_cnt(3);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0);
        check_eq("frozen_tick", int'(bus.tick), 0);
        run(15);

        // Reset at cnt==5 with a shadow pending
        run_to_cnt(1);
        step(0, 1, 1, 7, 2, 0, 0);
        run_to_cnt(5);
        check_eq("pend_before_rst", int'(bus.cfg_pend), 1);
        do_reset();
        check_eq("rst2_flag", int'(bus.flag), 1);
        check_eq("rst2_tick", int'(bus.tick), 0);
        check_eq("rst2_pend", int'(bus.cfg_pend), 0);
        run(22);

`ifdef PFG_ONESHOT_EN
        // One-shot: single tick, then done with flag low
        do_reset();
        ticks = 0;
        for (int i = 0; i < 25; i++) begin
            step(0, 1, 0, 0, 0, 0, 1);
            if (bus.tick) ticks++;
        end
        check_eq("os_ticks", ticks, 1);
        check_eq("os_done", int'(bus.done), 1);
        step(0, 1, 0, 0, 0, 1, 1);
        check_eq("os_restart_done", int'(bus.done), 0);
        check_eq("os_restart_flag", int'(bus.flag), 1);
        run_to_cnt(3);
        step(0, 1, 0, 0, 0, 1, 1);
        run(15);
        step(0, 1, 0, 0, 0, 0, 0);
        run(3);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 500) == 0, ($urandom % 8) != 0, ($urandom % 16) == 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 17)),
                 ($urandom % 12) == 0, ($urandom % 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/periodic_flag_gen.md
Name: periodic_flag_gen

Overview:
- Parametrised periodic flag/tick generator: a programmable-duty square wave plus a one-cycle wrap pulse, driven from the 1 MHz system clock.
- Replaces fixed-interval timers such as the 5 s sensor/display refresh flags.
- Period and high time come from compile-time defaults and can be reloaded at runtime through a shadowed config port.
- Sits beside the sensor polling and display logic as the common timebase.

Parameters:
- CNT_W, 23, width of counter and config values (max period 2^CNT_W-1 cycles)
- PERIOD, 5000000, reset-default period in clk1M cycles
- HIGH_CYCLES, 2500000, reset-default number of cycles per period that flag is high

Ports:
- clk1M  in  1  system clock (1 MHz)
- rst  in  1  synchronous reset, active-high
- en  in  1  count enable; low freezes all state
- cfg_ld  in  1  one-cycle strobe: capture cfg_period/cfg_high into shadow registers
- cfg_period  in  CNT_W  new period in cycles
- cfg_high  in  CNT_W  new high time in cycles
- flag  out  1  periodic level output, registered
- tick  out  1  one-cycle pulse on each period wrap, registered
- cfg_pend  out  1  shadow config loaded but not yet applied
- oneshot  in  1  (PFG_ONESHOT_EN only) 1 = stop after one period
- start  in  1  (PFG_ONESHOT_EN only) restart a finished one-shot
- done  out  1  (PFG_ONESHOT_EN only) one-shot period finished

Behaviour:
- Reset (rst=1 on a clk1M edge):
  - cnt=0; period_r=PERIOD; high_r=HIGH_CYCLES.
  - flag=(HIGH_CYCLES!=0); tick=0; cfg_pend=0; done=0.
- Effective period: P = max(period_r, 1). A value of 0 is treated as 1.
- Counter runs 0..P-1 while en=1.
  - At cnt==P-1: cnt<=0 and tick<=1.
  - Otherwise: cnt<=cnt+1 and tick<=0.
- Invariant after every edge: flag == (cnt < high_r), evaluated against the registered cnt and the config active in that cycle.
  - high_r=0: flag is constant 0.
  - high_r>=P: flag is constant 1.
- tick is high for exactly one cycle per period, in the cycle where cnt==0 following a wrap. tick is not asserted after reset.
- P=1: cnt stays 0, tick is high every enabled cycle, flag=(high_r!=0).
- en=0: cnt, flag and config registers hold; tick<=0. Resuming continues from the held cnt with no extra tick.
- Config shadowing:
  - cfg_ld=1 captures cfg_period/cfg_high into shadow registers and sets cfg_pend=1.
  - At the next wrap, period_r/high_r<=shadow and cfg_pend<=0. The new values govern the cycle with cnt=0, including the flag computed for it.
  - A second cfg_ld before the wrap overwrites the shadow (last write wins).
  - cfg_ld in the same cycle as a wrap: the current wrap applies the old shadow, or nothing if none is pending. The new values are applied at the following wrap, and cfg_pend stays 1.
- cfg_ld while en=0 still captures. It is applied at the first wrap after en returns high.
- rst has priority over all inputs, discards any pending shadow, and restores the parameter defaults.
- All arithmetic is unsigned CNT_W bits. cnt never exceeds P-1, so there is no wrap-around at 2^CNT_W.

Optional Feature:
- Macro: PFG_ONESHOT_EN.
- Defined:
  - Ports oneshot/start/done exist.
  - With oneshot=1, at the wrap the counter goes to cnt=0 and then stops: flag<=0, done<=1, and tick pulses once.
  - While done=1: cnt holds, flag=0, and no further ticks occur.
  - start=1 (with done=1): done<=0, cnt<=0, flag<=(high_r!=0). Counting resumes on the next edge.
  - start while done=0 is ignored.
  - Changing oneshot from 1 to 0 while done=1 does not restart the counter; start is still required.
  - rst clears done.
- Undefined: the ports are absent and the block is always continuous.

Test Plan:
- PERIOD=10, HIGH_CYCLES=4, en=1 after reset -> flag is 1 for 4 cycles and 0 for 6, repeating; tick pulses every 10 cycles, first at cycle 10 after reset release.
- cfg_ld with period=6, high=3 at cnt=2 -> cfg_pend=1 until the wrap; the next period is 6 cycles with 3 high; cfg_pend=0 after the wrap.
- cfg_ld at the wrap cycle, plus a second cfg_ld before the wrap (period=8, then period=12) -> the wrap cycle keeps old values; only period=12 is applied at the next wrap.
- Boundaries: high=0 gives flag always 0; high=15 with period=10 gives flag always 1; period=0 or 1 gives tick every cycle.
- en low for 7 cycles mid-period, and rst asserted at cnt=5 with a shadow pending -> en low freezes cnt, flag and tick=0, then the period completes normally on resume; the rst restores defaults, drops the pending config, and gives flag=1, tick=0.
- PFG_ONESHOT_EN, oneshot=1, PERIOD=10, HIGH=4 -> one tick, done=1, flag=0 held; start restarts the sequence; a second start while running is ignored.
